// File: rtl/seq_multiplier_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier_pkg
//  Description : Opcode and state encodings shared by the shift-add multiplier
//  Revision    : 1.0  initial release
// ============================================================================
package seq_multiplier_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic rs1_is_signed(input logic [1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic rs2_is_signed(input logic [1:0] op);
        return (op == OP_MULH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_multiplier_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder / ripple_adder
//  Description : One-bit full adder and the WIDTH-bit ripple chain built from it
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end
endmodule
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Iterative shift-add RV32M MUL/MULH/MULHSU/MULHU, one add per cycle
//  Revision    : 1.0  initial release
// ============================================================================
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);
    localparam int               CW   = $clog2(XLEN);
    localparam logic [CW-1:0]    LAST = CW'(XLEN - 1);

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   acc_hi_q, acc_hi_d;
    logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
    logic [CW-1:0]     count_q, count_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              valid_q, valid_d;

    logic              s1, s2;
    logic [XLEN-1:0]   rs1_mag, rs2_mag;
    logic [XLEN-1:0]   add_b, add_sum;
    logic              add_cout;
    logic [2*XLEN-1:0] prod_mag, prod;

    // Magnitude of the most negative value wraps to 2^(XLEN-1), which is exact unsigned.
    assign s1      = rs1_is_signed(op) & rs1[XLEN-1];
    assign s2      = rs2_is_signed(op) & rs2[XLEN-1];
    assign rs1_mag = s1 ? (~rs1 + 1'b1) : rs1;
    assign rs2_mag = s2 ? (~rs2 + 1'b1) : rs2;

    assign add_b = acc_lo_q[0] ? mcand_q : '0;

    ripple_adder #(.WIDTH(XLEN)) u_adder (
        .a    (acc_hi_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Accumulator contents after the final shift, then sign correction.
    assign prod_mag = {add_cout, add_sum, acc_lo_q[XLEN-1:1]};
    assign prod     = neg_q ? (~prod_mag + 1'b1) : prod_mag;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        count_d  = count_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_BUSY;
                    op_d     = op;
                    mcand_d  = rs1_mag;
                    neg_d    = s1 ^ s2;
                    acc_hi_d = '0;
                    acc_lo_d = rs2_mag;
                    count_d  = '0;
                end
            end
            S_BUSY: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_hi_d = {add_cout, add_sum[XLEN-1:1]};
                    acc_lo_d = {add_sum[0], acc_lo_q[XLEN-1:1]};
                    count_d  = count_q + CW'(1);
                    if (count_q == LAST) begin
                        state_d  = S_DONE;
                        result_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                        valid_d  = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            count_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            count_q  <= count_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign valid  = valid_q;
    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_multiplier
//  Description : Self-checking bench: directed table, corner sequences, random ops
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1, rs2;
    logic        kill;
    logic        busy, valid;
    logic [31:0] result;

    int n_checks = 0;
    int n_err    = 0;

    seq_multiplier #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .kill   (kill),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    // Reference: extend each operand to 64 bits according to its signedness and multiply.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
    endtask

    // Counts edges from the accepting edge (edge 1) until valid is seen.
    task automatic wait_valid(input int restart_at, input logic [31:0] b2,
                              output int lat, output logic [31:0] res, output int busy_bad);
        lat      = -1;
        res      = 'x;
        busy_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1 || k == restart_at + 1) start = 1'b0;
            if (!busy) busy_bad++;
            if (valid) begin
                lat = k;
                res = result;
                break;
            end
            if (k == restart_at) begin
                rs2   = b2;
                start = 1'b1;
            end
        end
    endtask

    task automatic run_check(input string name, input logic [1:0] o,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int lat, bb;
        logic [31:0] res;
        issue(o, a, b);
        wait_valid(0, '0, lat, res, bb);
        check({name, " result"}, res, exp);
        check({name, " latency"}, lat, 33);
        @(posedge clk); #1;
        check({name, " valid pulse width"}, {31'b0, valid}, 0);
    endtask

    vec_t vecs[$];

    initial begin
        int lat, bb;
        logic [31:0] res;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs.push_back('{"mul 7*-3",           2'b00, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB});
        vecs.push_back('{"mulh min*min",       2'b01, 32'h80000000, 32'h80000000, 32'h40000000});
        vecs.push_back('{"mulh -1*1",          2'b01, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF});
        vecs.push_back('{"mulhsu -1*max",      2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
        vecs.push_back('{"mulhu max*max",      2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
        vecs.push_back('{"mul max*max",        2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001});
        vecs.push_back('{"mul zero",           2'b00, 32'h0,        32'h00012345, 32'h00000000});
        vecs.push_back('{"mulh min*maxpos",    2'b01, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000});

        rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
        #12;
        check("reset busy",   {31'b0, busy},  0);
        check("reset valid",  {31'b0, valid}, 0);
        check("reset result", result,         0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Second start four cycles in must be ignored.
        issue(2'b00, 32'd3, 32'd5);
        wait_valid(4, 32'd9, lat, res, bb);
        check("ignored start result",  res, 32'd15);
        check("ignored start latency", lat, 33);
        check("ignored start busy",    bb,  0);
        @(posedge clk); #1;
        check("ignored start no requeue", {31'b0, busy}, 0);

        // Kill mid-operation, then restart straight away.
        issue(2'b11, 32'h12345678, 32'h9ABCDEF0);
        bb = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (valid) bb++;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill busy",  {31'b0, busy}, 0);
        check("kill valid", {31'b0, valid | (bb != 0)}, 0);
        issue(2'b01, 32'hFFFF0001, 32'h00001234);
        wait_valid(0, '0, lat, res, bb);
        check("post-kill result",  res, model(2'b01, 32'hFFFF0001, 32'h00001234));
        check("post-kill latency", lat, 33);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an operation.
        issue(2'b10, 32'h87654321, 32'h0BADF00D);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("async rst busy",   {31'b0, busy},  0);
        check("async rst valid",  {31'b0, valid}, 0);
        check("async rst result", result,         0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_check("mulhu after rst", 2'b11, 32'h0000FFFF, 32'h00010000, 32'h00000000);
        run_check("mul after rst",   2'b00, 32'h0000FFFF, 32'h00010000, 32'hFFFF0000);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 1) ra = 32'h80000000;
            if (i % 6 == 3) rb = 32'h80000000;
            if (i % 6 == 5) rb = 32'h0;
            issue(ro, ra, rb);
            wait_valid(0, '0, lat, res, bb);
            check($sformatf("rand%0d op%0d %h*%h", i, ro, ra, rb), res, model(ro, ra, rb));
            check($sformatf("rand%0d latency", i), lat, 33);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
